// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select codes
// and the sequential fetch increment.
package pc_pkg;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_REL  = 2'b10,
    PS_ABS  = 2'b11
  } ps_t;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push on a full stack overwrites the oldest
// entry; pop+push in one cycle replaces the top in place.
module ras_stack #(
  parameter int WIDTH     = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_dec;

  // sp names the next free slot; the top lives one below it (mod depth)
  assign sp_dec = sp - 1'b1;
  assign top    = mem[sp_dec];
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      sp    <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      sp    <= sp;
      count <= count;
    end else if (push) begin
      sp    <= sp + 1'b1;
      count <= full ? count : count + 1'b1;
    end else if (pop && !empty) begin
      sp    <= sp_dec;
      count <= count - 1'b1;
    end
  end

  // Data storage is not reset; stale entries are unreachable once count is 0
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push && pop && !empty) mem[sp_dec] <= din;
      else if (push)             mem[sp]     <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects hold/increment/relative/absolute next PC
// with a return-address stack for call/return.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              WIDTH        = 64,
  parameter int              RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [1:0]       PS,
  input  logic [WIDTH-1:0] X,
  input  logic             link,
  input  logic             ret,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] PC4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign,
  output logic             ras_underflow
);

  logic [WIDTH-1:0]        pc_next;
  logic [WIDTH-1:0]        ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic signed [WIDTH-1:0] rel_off;
  logic                    do_push;
  logic                    do_pop;
  logic                    misalign_next;
  logic                    underflow_next;

  assign PC4     = PC_out + WIDTH'(PC_INC);
  assign rel_off = $signed(X) <<< 2;
  assign do_push = load && link;
  assign do_pop  = load && ret;

  always_comb begin
    pc_next        = PC_out;
    misalign_next  = 1'b0;
    underflow_next = 1'b0;
    if (do_pop) begin
      pc_next        = ras_empty ? PC4 : ras_top;
      underflow_next = ras_empty;
    end else if (load) begin
      unique case (ps_t'(PS))
        PS_HOLD: pc_next = PC_out;
        PS_INC:  pc_next = PC4;
        PS_REL:  pc_next = PC_out + rel_off;
        PS_ABS: begin
          pc_next       = {X[WIDTH-1:2], 2'b00};
          misalign_next = (X[1:0] != 2'b00);
        end
        default: pc_next = PC_out;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      PC_out        <= RESET_VECTOR;
      misalign      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      PC_out        <= pc_next;
      misalign      <= misalign_next;
      ras_underflow <= underflow_next;
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock (clock),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .din   (PC4),
    .top   (ras_top),
    .count (ras_count),
    .empty (ras_empty),
    .full  (ras_full)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (WIDTH=64, RAS_DEPTH=4) with hand-computed
// expected values checked by immediate assertions.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load  = 1'b0;
  logic [1:0]  PS    = 2'b00;
  logic [63:0] X     = '0;
  logic        link  = 1'b0;
  logic        ret   = 1'b0;
  logic [63:0] PC_out;
  logic [63:0] PC4;
  logic        ras_empty;
  logic        ras_full;
  logic        misalign;
  logic        ras_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(
    .WIDTH        (64),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (64'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .PS            (PS),
    .X             (X),
    .link          (link),
    .ret           (ret),
    .PC_out        (PC_out),
    .PC4           (PC4),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .misalign      (misalign),
    .ras_underflow (ras_underflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [1:0] ps, input logic [63:0] x,
                       input logic lk, input logic rt);
    load = ld; PS = ps; X = x; link = lk; ret = rt;
    step();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("rst_pc", PC_out, 64'h0);
    chk("rst_pc4", PC4, 64'h4);
    chk("rst_empty", {63'h0, ras_empty}, 64'h1);
    chk("rst_full", {63'h0, ras_full}, 64'h0);
    chk("rst_flags", {62'h0, misalign, ras_underflow}, 64'h0);

    // sequential increment
    drive(1'b1, 2'b01, 64'h0, 1'b0, 1'b0);
    chk("inc1_pc", PC_out, 64'h4);
    chk("inc1_pc4", PC4, 64'h8);
    drive(1'b1, 2'b01, 64'h0, 1'b0, 1'b0);
    chk("inc2_pc", PC_out, 64'h8);
    drive(1'b1, 2'b01, 64'h0, 1'b0, 1'b0);
    chk("inc3_pc", PC_out, 64'hC);
    chk("inc3_pc4", PC4, 64'h10);

    // hold
    drive(1'b1, 2'b00, 64'h0, 1'b0, 1'b0);
    chk("hold_pc", PC_out, 64'hC);

    // relative with negative offset
    drive(1'b1, 2'b11, 64'h100, 1'b0, 1'b0);
    chk("abs_pc", PC_out, 64'h100);
    drive(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    chk("rel_neg_pc", PC_out, 64'hF8);

    // wraparound on increment
    drive(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    chk("abs_top_pc", PC_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc4", PC4, 64'h0);
    drive(1'b1, 2'b01, 64'h0, 1'b0, 1'b0);
    chk("wrap_pc", PC_out, 64'h0);

    // misaligned absolute, then stall
    drive(1'b1, 2'b11, 64'h40, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 64'h203, 1'b0, 1'b0);
    chk("mis_pc", PC_out, 64'h200);
    chk("mis_flag", {63'h0, misalign}, 64'h1);
    drive(1'b0, 2'b01, 64'h0, 1'b1, 1'b1);
    chk("stall_pc", PC_out, 64'h200);
    chk("stall_mis", {63'h0, misalign}, 64'h0);
    chk("stall_empty", {63'h0, ras_empty}, 64'h1);

    // five links fill and wrap the RAS
    drive(1'b1, 2'b11, 64'h0, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 64'h10, 1'b1, 1'b0);
    chk("lnk1_pc", PC_out, 64'h10);
    chk("lnk1_empty", {63'h0, ras_empty}, 64'h0);
    drive(1'b1, 2'b11, 64'h20, 1'b1, 1'b0);
    drive(1'b1, 2'b11, 64'h30, 1'b1, 1'b0);
    drive(1'b1, 2'b11, 64'h40, 1'b1, 1'b0);
    chk("lnk4_full", {63'h0, ras_full}, 64'h1);
    drive(1'b1, 2'b11, 64'h100, 1'b1, 1'b0);
    chk("lnk5_full", {63'h0, ras_full}, 64'h1);
    chk("lnk5_pc", PC_out, 64'h100);

    // four returns, newest first
    drive(1'b1, 2'b11, 64'h999, 1'b0, 1'b1);
    chk("ret1_pc", PC_out, 64'h44);
    chk("ret1_full", {63'h0, ras_full}, 64'h0);
    drive(1'b1, 2'b11, 64'h999, 1'b0, 1'b1);
    chk("ret2_pc", PC_out, 64'h34);
    drive(1'b1, 2'b11, 64'h999, 1'b0, 1'b1);
    chk("ret3_pc", PC_out, 64'h24);
    drive(1'b1, 2'b11, 64'h999, 1'b0, 1'b1);
    chk("ret4_pc", PC_out, 64'h14);
    chk("ret4_empty", {63'h0, ras_empty}, 64'h1);
    chk("ret4_uf", {63'h0, ras_underflow}, 64'h0);

    // underflow
    drive(1'b1, 2'b11, 64'h999, 1'b0, 1'b1);
    chk("uf_pc", PC_out, 64'h18);
    chk("uf_flag", {63'h0, ras_underflow}, 64'h1);
    chk("uf_empty", {63'h0, ras_empty}, 64'h1);
    drive(1'b1, 2'b00, 64'h0, 1'b0, 1'b0);
    chk("uf_clear", {63'h0, ras_underflow}, 64'h0);

    // simultaneous link+ret replaces top
    drive(1'b1, 2'b11, 64'h80, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 64'h200, 1'b1, 1'b0);
    chk("lr_setup_pc", PC_out, 64'h200);
    drive(1'b1, 2'b01, 64'h0, 1'b1, 1'b1);
    chk("lr_pc", PC_out, 64'h84);
    chk("lr_empty", {63'h0, ras_empty}, 64'h0);
    chk("lr_full", {63'h0, ras_full}, 64'h0);
    drive(1'b1, 2'b01, 64'h0, 1'b0, 1'b1);
    chk("lr_top_pc", PC_out, 64'h204);
    chk("lr_after_empty", {63'h0, ras_empty}, 64'h1);

    // reset overrides a concurrent push and absolute jump
    drive(1'b1, 2'b11, 64'h500, 1'b1, 1'b0);
    chk("pre_rst_empty", {63'h0, ras_empty}, 64'h0);
    drive(1'b1, 2'b11, 64'h303, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 2'b11, 64'h703, 1'b1, 1'b0);
    reset = 1'b0;
    chk("rst2_pc", PC_out, 64'h0);
    chk("rst2_empty", {63'h0, ras_empty}, 64'h1);
    chk("rst2_flags", {62'h0, misalign, ras_underflow}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
